grf_wb_queue: RTL and testbench
===============================

# grf_wb_queue

Write-back queue that buffers register-file write requests and drains them, in order, onto the single write port of the general register file (A3/WD3/WE plus the instruction pc used for the write log). It sits between the datapath's write-back producers and the register file. Bursts of write-backs, for example from multi-cycle units, are absorbed with a valid/ready handshake instead of being lost. A held drain models a busy register file.

## Interface
- DEPTH, 4, number of queue entries; power of two, ≥2
- clk  input  1  clock; all state updates on posedge
- reset  input  1  synchronous, active-high; clears the queue
- in_valid  input  1  producer has a write request
- in_ready  output  1  queue can accept; equals !full
- in_addr  input  5  destination register number
- in_data  input  32  write data
- in_pc  input  32  pc of the producing instruction
- wb_hold  input  1  register file not accepting this cycle
- wb_we  output  1  write-enable to the register file
- wb_a3  output  5  write address
- wb_wd  output  32  write data
- wb_pc  output  32  pc forwarded for the write log
- count  output  $clog2(DEPTH+1)  current occupancy
- empty  output  1  count==0
- full  output  1  count==DEPTH
- q_addr  input  5  bypass lookup address (only with GRF_WB_BYPASS_EN)
- q_hit  output  1  a pending entry matches q_addr (only with GRF_WB_BYPASS_EN)
- q_data  output  32  newest pending data for q_addr (only with GRF_WB_BYPASS_EN)

## Operation
- Circular FIFO of DEPTH entries {addr, data, pc}, with head pointer, tail pointer and count.
- Enqueue happens when in_valid && in_ready at a clock edge. The entry is written at the tail and the tail advances modulo DEPTH.
- Dequeue happens when wb_we at a clock edge. The head advances modulo DEPTH.
- wb_we = !empty && !wb_hold, combinational.
- wb_a3, wb_wd and wb_pc always show the head entry. They are don't-care when empty, but must not be X after reset: the storage resets to 0.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance.
- in_ready = !full. A dequeue in the same cycle does not open a slot while the queue is full.
- Writes to $0 are queued and issued like any other write, because the register file itself discards them.
- Strict FIFO order: two writes to the same register reach the register file in arrival order.
- count increments on enqueue-only, decrements on dequeue-only, and is otherwise held.
- Reset:
  - Pointers and count go to 0.
  - Storage is cleared.
  - Any enqueue presented in the reset cycle is dropped.
  - After reset: empty=1, full=0, in_ready=1, wb_we=0, wb_a3/wb_wd/wb_pc=0, q_hit=0, q_data=0.
  - Reset mid-drain discards every pending entry with no further wb_we.

## Timing
- Minimum latency is 1 cycle. An entry accepted at edge N drives wb_we in the cycle after edge N, provided wb_hold=0 and it is at the head. There is no same-cycle passthrough from in_* to wb_*.
- With no holds, throughput is one write per cycle in and one write per cycle out.
- wb_hold freezes the head. Outputs stay stable while held.
- in_ready, empty, full and count change only after clock edges or reset.

## Configuration
- GRF_WB_BYPASS_EN defined:
  - q_hit/q_data are present.
  - q_hit=1 when q_addr!=0 and any valid entry has addr==q_addr.
  - q_data is the data of the newest (closest to tail) matching entry.
  - The lookup is combinational over the current contents only; a same-cycle in_* request is not considered.
  - q_addr=0 gives q_hit=0, q_data=0.
- GRF_WB_BYPASS_EN undefined: the q_* ports and the lookup logic are absent.

## Structure
- Shared package grf_pkg holds:
  - REG_AW=5 and DATA_W=32
  - a wb_entry_t struct {addr, data, pc}
  - the zero-register constant REG_ZERO=5'd0
- One sub-module, grf_wb_lookup: a newest-match priority search over the entries. It is instantiated only under GRF_WB_BYPASS_EN.

## Test plan
- Reset then idle:
  - Stimulus: assert reset for 2 cycles, then release.
  - Required: empty=1, in_ready=1, count=0, wb_we=0 for 5 cycles.
- Single write:
  - Stimulus: enqueue {addr=5, data=0x1234ABCD, pc=0x3000}.
  - Required: the next cycle shows wb_we=1, wb_a3=5, wb_wd=0x1234ABCD, wb_pc=0x3000; the following cycle shows empty=1.
- Fill under hold:
  - Stimulus: wb_hold=1 while enqueueing DEPTH+1 writes.
  - Required: full=1 and in_ready=0 after DEPTH accepts; the extra write is not taken.
  - Then release hold: exactly DEPTH writes emerge in order, one per cycle.
- Simultaneous push/pop:
  - Stimulus: steady stream of in_valid=1 with wb_hold=0.
  - Required: count stays 1 and output order equals input order across pointer wrap (≥2·DEPTH writes).
- Same-register ordering plus bypass (GRF_WB_BYPASS_EN):
  - Stimulus: with hold, enqueue $8←0x11 then $8←0x22; set q_addr=8.
  - Required: q_hit=1, q_data=0x22; after draining, the register file shows $8=0x22.
  - Also: q_addr=0 gives q_hit=0 even after enqueueing an addr=0 write.
- Reset mid-drain:
  - Stimulus: 3 pending entries under hold; assert reset with wb_hold=0.
  - Required: wb_we=0 from the reset cycle onward, count=0, and no stale entries ever appear.

Source files
------------

// File: rtl/grf_pkg.sv
// grf_pkg: shared register-file widths, zero-register constant and write-back entry type
package grf_pkg;
  localparam int REG_AW = 5;
  localparam int DATA_W = 32;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] pc;
  } wb_entry_t;
endpackage

// File: rtl/grf_wb_lookup.sv
// grf_wb_lookup: finds the newest pending entry whose destination matches a lookup address
module grf_wb_lookup
  import grf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wb_entry_t                      entries_i [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]       head_i,
  input  logic [$clog2(DEPTH+1)-1:0]     count_i,
  input  logic [REG_AW-1:0]              addr_i,
  output logic                           hit_o,
  output logic [DATA_W-1:0]              data_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [PW-1:0] idx;
  // Walk oldest to newest so the last match left standing is the newest one
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_i + PW'(k);
      if (CW'(k) < count_i && addr_i != REG_ZERO && entries_i[idx].addr == addr_i) begin
        hit_o  = 1'b1;
        data_o = entries_i[idx].data;
      end
    end
  end
endmodule

// File: rtl/grf_wb_queue.sv
// grf_wb_queue: in-order write-back FIFO feeding the register file write port; GRF_WB_BYPASS_EN adds a pending-write lookup
module grf_wb_queue
  import grf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [REG_AW-1:0]          in_addr,
  input  logic [DATA_W-1:0]          in_data,
  input  logic [DATA_W-1:0]          in_pc,
  input  logic                       wb_hold,
  output logic                       wb_we,
  output logic [REG_AW-1:0]          wb_a3,
  output logic [DATA_W-1:0]          wb_wd,
  output logic [DATA_W-1:0]          wb_pc,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
`ifdef GRF_WB_BYPASS_EN
  ,
  input  logic [REG_AW-1:0]          q_addr,
  output logic                       q_hit,
  output logic [DATA_W-1:0]          q_data
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  wb_entry_t     mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;
  assign empty    = count_q == '0;
  assign full     = count_q == CW'(DEPTH);
  assign count    = count_q;
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign wb_we    = !empty && !wb_hold && !reset;
  assign pop      = wb_we;
  assign wb_a3    = mem_q[head_q].addr;
  assign wb_wd    = mem_q[head_q].data;
  assign wb_pc    = mem_q[head_q].pc;
  // Pointer and occupancy next-state; power-of-two depth makes wrap free
  always_comb begin
    head_d  = pop ? head_q + PW'(1) : head_q;
    tail_d  = push ? tail_q + PW'(1) : tail_q;
    count_d = (push && !pop) ? count_q + CW'(1) : (pop && !push) ? count_q - CW'(1) : count_q;
  end
  // State and storage; reset clears contents so the head outputs are never X
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push) mem_q[tail_q] <= '{addr: in_addr, data: in_data, pc: in_pc};
    end
  end
`ifdef GRF_WB_BYPASS_EN
  grf_wb_lookup #(.DEPTH(DEPTH)) u_lookup (
    .entries_i (mem_q),
    .head_i    (head_q),
    .count_i   (count_q),
    .addr_i    (q_addr),
    .hit_o     (q_hit),
    .data_o    (q_data)
  );
`endif
endmodule

// File: tb/tb_grf_wb_queue.sv
// tb_grf_wb_queue: directed self-checking bench for the write-back queue
module tb_grf_wb_queue;
  import grf_pkg::*;
  localparam int DEPTH = 4;
  logic              clk, reset, in_valid, in_ready, wb_hold, wb_we, empty, full;
  logic [4:0]        in_addr, wb_a3;
  logic [31:0]       in_data, in_pc, wb_wd, wb_pc;
  logic [2:0]        count;
  logic [4:0]        q_addr;
  logic              q_hit;
  logic [31:0]       q_data;
  logic [31:0]       rf [32];
  int                tests, fails;

  grf_wb_queue #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .in_pc    (in_pc),
    .wb_hold  (wb_hold),
    .wb_we    (wb_we),
    .wb_a3    (wb_a3),
    .wb_wd    (wb_wd),
    .wb_pc    (wb_pc),
    .count    (count),
    .empty    (empty),
    .full     (full)
`ifdef GRF_WB_BYPASS_EN
    ,
    .q_addr   (q_addr),
    .q_hit    (q_hit),
    .q_data   (q_data)
`endif
  );

`ifndef GRF_WB_BYPASS_EN
  assign q_hit  = 1'b0;
  assign q_data = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (wb_we && wb_a3 != 5'd0) rf[wb_a3] <= wb_wd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_in(input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    in_pc    = p;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    reset = 1'b1;
    wb_hold = 1'b0;
    q_addr = '0;
    push_in(5'd7, 32'hDEAD_BEEF, 32'h100);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_a3", 32'(wb_a3), 32'd0);
    chk("rst_wd", wb_wd, 32'd0);
    chk("rst_pc", wb_pc, 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_qhit", 32'(q_hit), 32'd0);
    chk("rst_qdata", q_data, 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk("idle_empty", 32'(empty), 32'd1);
      chk("idle_ready", 32'(in_ready), 32'd1);
      chk("idle_count", 32'(count), 32'd0);
      chk("idle_we", 32'(wb_we), 32'd0);
      @(negedge clk);
      #1;
    end
    push_in(5'd5, 32'h1234_ABCD, 32'h3000);
    chk("single_no_passthru", 32'(wb_we), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("single_we", 32'(wb_we), 32'd1);
    chk("single_a3", 32'(wb_a3), 32'd5);
    chk("single_wd", wb_wd, 32'h1234_ABCD);
    chk("single_pc", wb_pc, 32'h3000);
    chk("single_count", 32'(count), 32'd1);
    @(negedge clk);
    #1;
    chk("single_empty", 32'(empty), 32'd1);
    chk("single_we_off", 32'(wb_we), 32'd0);
    wb_hold = 1'b1;
    for (int i = 0; i <= DEPTH; i++) begin
      push_in(5'(10 + i), 32'hA0 + 32'(i), 32'h4000 + 32'(4 * i));
      #1;
      chk("fill_ready", 32'(in_ready), (i < DEPTH) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_ready_low", 32'(in_ready), 32'd0);
    chk("fill_count", 32'(count), 32'd4);
    chk("hold_we", 32'(wb_we), 32'd0);
    chk("hold_a3", 32'(wb_a3), 32'd10);
    @(negedge clk);
    #1;
    chk("hold_stable_a3", 32'(wb_a3), 32'd10);
    chk("hold_stable_wd", wb_wd, 32'hA0);
    wb_hold = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      chk("drain_we", 32'(wb_we), 32'd1);
      chk("drain_a3", 32'(wb_a3), 32'(10 + i));
      chk("drain_wd", wb_wd, 32'hA0 + 32'(i));
      chk("drain_pc", wb_pc, 32'h4000 + 32'(4 * i));
      @(negedge clk);
    end
    #1;
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_we_off", 32'(wb_we), 32'd0);
    for (int i = 0; i < 10; i++) begin
      push_in(5'(i + 1), 32'hB000 + 32'(i), 32'h5000 + 32'(i));
      #1;
      if (i > 0) begin
        chk("stream_we", 32'(wb_we), 32'd1);
        chk("stream_wd", wb_wd, 32'hB000 + 32'(i - 1));
        chk("stream_count", 32'(count), 32'd1);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    chk("stream_last", wb_wd, 32'hB009);
    @(negedge clk);
    #1;
    chk("stream_empty", 32'(empty), 32'd1);
    wb_hold = 1'b1;
    push_in(5'd8, 32'h11, 32'h600);
    @(negedge clk);
    push_in(5'd8, 32'h22, 32'h604);
    @(negedge clk);
    push_in(5'd0, 32'h33, 32'h608);
    @(negedge clk);
    in_valid = 1'b0;
`ifdef GRF_WB_BYPASS_EN
    q_addr = 5'd8;
    #1;
    chk("byp_hit", 32'(q_hit), 32'd1);
    chk("byp_data", q_data, 32'h22);
    q_addr = 5'd0;
    #1;
    chk("byp_zero_hit", 32'(q_hit), 32'd0);
    chk("byp_zero_data", q_data, 32'd0);
    q_addr = 5'd9;
    #1;
    chk("byp_miss", 32'(q_hit), 32'd0);
`endif
    @(negedge clk);
    wb_hold = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("zero_we", 32'(wb_we), 32'd1);
    chk("zero_a3", 32'(wb_a3), 32'd0);
    @(negedge clk);
    #1;
    chk("order_rf8", rf[8], 32'h22);
    chk("order_empty", 32'(empty), 32'd1);
    wb_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_in(5'(20 + i), 32'hC0 + 32'(i), 32'h700);
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    chk("mid_count", 32'(count), 32'd3);
    wb_hold = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid_rst_we", 32'(wb_we), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_count0", 32'(count), 32'd0);
    chk("mid_empty", 32'(empty), 32'd1);
    chk("mid_a3", 32'(wb_a3), 32'd0);
    chk("mid_wd", wb_wd, 32'd0);
    chk("mid_rf20", rf[20], 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("mid_we_off", 32'(wb_we), 32'd0);
      @(negedge clk);
      #1;
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
